// File: rtl/wb_addr_decoder_pkg.sv
// Shared types and default address map for the Wishbone address decoder.
// Four 256 MiB windows at 0x0000_0000, 0x1000_0000, 0x2000_0000 and 0x3000_0000.
package wb_addr_decoder_pkg;

    localparam int NUM_SLAVES = 4;

    localparam logic [NUM_SLAVES*32-1:0] DEFAULT_SLAVE_BASE =
        {32'h3000_0000, 32'h2000_0000, 32'h1000_0000, 32'h0000_0000};
    localparam logic [NUM_SLAVES*32-1:0] DEFAULT_SLAVE_MASK = {4{32'hF000_0000}};

    typedef enum logic [1:0] {
        IDLE,
        ACTIVE,
        ERROR
    } dec_state_t;

endpackage

// File: rtl/wb_addr_decoder_if.sv
// Classic Wishbone bus bundle; the master modport drives the request, the slave modport answers.
// Purely a wiring bundle: no latency, and backpressure is the slave holding off ACK.
interface wb_if #(
    parameter int AW = 32,
    parameter int DW = 32
);
    logic [AW-1:0]   ADR;
    logic [DW-1:0]   DAT_W;
    logic [DW-1:0]   DAT_R;
    logic            WE;
    logic [DW/8-1:0] SEL;
    logic            CYC;
    logic            STB;
    logic [2:0]      CTI;
    logic [1:0]      BTE;
    logic            ACK;
    logic            ERR;

    modport master (
        output ADR, DAT_W, WE, SEL, CYC, STB, CTI, BTE,
        input  DAT_R, ACK, ERR
    );

    modport slave (
        input  ADR, DAT_W, WE, SEL, CYC, STB, CTI, BTE,
        output DAT_R, ACK, ERR
    );
endinterface

// File: rtl/wb_addr_decoder_watchdog.sv
// Counts cycles a selected slave has left a request unanswered; o_expire is combinational on the
// final allowed cycle. Stalls (holds its count) once expired until cleared; no backpressure.
module wb_watchdog #(
    parameter int TIMEOUT_CYCLES = 255
) (
    input  logic wb_clk,
    input  logic rst,
    input  logic i_clear,
    input  logic i_enable,
    output logic o_expire
);

    logic [15:0] r_count;

    always_ff @(posedge wb_clk) begin
        if (rst || i_clear) begin
            r_count <= '0;
        end else if (i_enable && !o_expire) begin
            r_count <= r_count + 16'd1;
        end
    end

    assign o_expire = i_enable && (r_count == 16'(TIMEOUT_CYCLES - 1));

endmodule

// File: rtl/wb_addr_decoder.sv
// One-master, four-slave Wishbone address decoder with a response watchdog; request registered
// (slave sees it one cycle after STB), response passed back combinationally; slave ACK is the backpressure.
module wb_addr_decoder
    import wb_addr_decoder_pkg::*;
#(
    parameter int                                     WB_ADDRESS_WIDTH = 32,
    parameter int                                     WB_DATA_WIDTH    = 32,
    parameter logic [NUM_SLAVES*WB_ADDRESS_WIDTH-1:0] SLAVE_BASE       = DEFAULT_SLAVE_BASE,
    parameter logic [NUM_SLAVES*WB_ADDRESS_WIDTH-1:0] SLAVE_MASK       = DEFAULT_SLAVE_MASK,
    parameter int                                     TIMEOUT_CYCLES   = 255,
    parameter bit                                     ERR_AS_ACK       = 1'b1,
    parameter logic [WB_DATA_WIDTH-1:0]               ERR_DATA         = 32'hDEAD_BEEF
) (
    input  logic wb_clk,
    input  logic rst,
    wb_if.slave  wb_i,
    wb_if.master m0_o,
    wb_if.master m1_o,
    wb_if.master m2_o,
    wb_if.master m3_o
);

    localparam int AW = WB_ADDRESS_WIDTH;

    dec_state_t              r_state;
    dec_state_t              w_next;
    logic [NUM_SLAVES-1:0]   r_sel;
    logic [NUM_SLAVES-1:0]   w_match_sel;
    logic [NUM_SLAVES-1:0]   w_port_en;
    logic [NUM_SLAVES-1:0]   w_s_ack;
    logic [NUM_SLAVES-1:0]   w_s_err;
    logic [WB_DATA_WIDTH-1:0] w_s_dat [NUM_SLAVES];
    logic                    w_req;
    logic                    w_active;
    logic                    w_sel_ack;
    logic                    w_sel_err;
    logic                    w_wd_clear;
    logic                    w_wd_expire;

    assign w_req = wb_i.CYC & wb_i.STB;

    // Scan from the top index down so the lowest matching slave is the last writer and wins.
    always_comb begin
        w_match_sel = '0;
        for (int i = NUM_SLAVES - 1; i >= 0; i--) begin
            if ((wb_i.ADR & SLAVE_MASK[i*AW +: AW]) == (SLAVE_BASE[i*AW +: AW] & SLAVE_MASK[i*AW +: AW])) begin
                w_match_sel    = '0;
                w_match_sel[i] = 1'b1;
            end
        end
    end

    // Reset gates every output combinationally so a mid-transaction reset is silent immediately.
    assign w_active  = (r_state == ACTIVE) && !rst;
    assign w_port_en = w_active ? r_sel : '0;
    assign w_sel_ack = w_active && wb_i.CYC && |(r_sel & w_s_ack);
    assign w_sel_err = w_active && wb_i.CYC && |(r_sel & w_s_err);

    always_ff @(posedge wb_clk) begin
        if (rst) begin
            r_state <= IDLE;
            r_sel   <= '0;
        end else begin
            r_state <= w_next;
            if (r_state == IDLE && w_req) begin
                r_sel <= w_match_sel;
            end
        end
    end

    always_comb begin
        w_next     = r_state;
        w_wd_clear = 1'b0;
        case (r_state)
            IDLE: begin
                if (w_req) begin
                    w_wd_clear = 1'b1;
                    w_next     = (|w_match_sel) ? ACTIVE : ERROR;
                end
            end
            ACTIVE: begin
                if (!wb_i.CYC || w_sel_ack || w_sel_err) begin
                    w_next = IDLE;
                end else if (w_wd_expire) begin
                    w_next = ERROR;
                end
            end
            default: w_next = IDLE;
        endcase
    end

    wb_watchdog #(
        .TIMEOUT_CYCLES(TIMEOUT_CYCLES)
    ) u_watchdog (
        .wb_clk  (wb_clk),
        .rst     (rst),
        .i_clear (w_wd_clear),
        .i_enable(w_active),
        .o_expire(w_wd_expire)
    );

    always_comb begin
        wb_i.DAT_R = '0;
        wb_i.ACK   = 1'b0;
        wb_i.ERR   = 1'b0;
        if (w_active) begin
            wb_i.ACK = w_sel_ack;
            wb_i.ERR = w_sel_err;
            for (int i = 0; i < NUM_SLAVES; i++) begin
                if (r_sel[i]) begin
                    wb_i.DAT_R = w_s_dat[i];
                end
            end
        end else if (r_state == ERROR && !rst) begin
            wb_i.DAT_R = ERR_DATA;
            wb_i.ACK   = ERR_AS_ACK;
            wb_i.ERR   = !ERR_AS_ACK;
        end
    end

    assign w_s_ack    = {m3_o.ACK, m2_o.ACK, m1_o.ACK, m0_o.ACK};
    assign w_s_err    = {m3_o.ERR, m2_o.ERR, m1_o.ERR, m0_o.ERR};
    assign w_s_dat[0] = m0_o.DAT_R;
    assign w_s_dat[1] = m1_o.DAT_R;
    assign w_s_dat[2] = m2_o.DAT_R;
    assign w_s_dat[3] = m3_o.DAT_R;

    assign m0_o.CYC   = w_port_en[0] & wb_i.CYC;
    assign m0_o.STB   = w_port_en[0] & wb_i.STB;
    assign m0_o.ADR   = w_port_en[0] ? wb_i.ADR   : '0;
    assign m0_o.DAT_W = w_port_en[0] ? wb_i.DAT_W : '0;
    assign m0_o.WE    = w_port_en[0] & wb_i.WE;
    assign m0_o.SEL   = w_port_en[0] ? wb_i.SEL   : '0;
    assign m0_o.CTI   = w_port_en[0] ? wb_i.CTI   : '0;
    assign m0_o.BTE   = w_port_en[0] ? wb_i.BTE   : '0;

    assign m1_o.CYC   = w_port_en[1] & wb_i.CYC;
    assign m1_o.STB   = w_port_en[1] & wb_i.STB;
    assign m1_o.ADR   = w_port_en[1] ? wb_i.ADR   : '0;
    assign m1_o.DAT_W = w_port_en[1] ? wb_i.DAT_W : '0;
    assign m1_o.WE    = w_port_en[1] & wb_i.WE;
    assign m1_o.SEL   = w_port_en[1] ? wb_i.SEL   : '0;
    assign m1_o.CTI   = w_port_en[1] ? wb_i.CTI   : '0;
    assign m1_o.BTE   = w_port_en[1] ? wb_i.BTE   : '0;

    assign m2_o.CYC   = w_port_en[2] & wb_i.CYC;
    assign m2_o.STB   = w_port_en[2] & wb_i.STB;
    assign m2_o.ADR   = w_port_en[2] ? wb_i.ADR   : '0;
    assign m2_o.DAT_W = w_port_en[2] ? wb_i.DAT_W : '0;
    assign m2_o.WE    = w_port_en[2] & wb_i.WE;
    assign m2_o.SEL   = w_port_en[2] ? wb_i.SEL   : '0;
    assign m2_o.CTI   = w_port_en[2] ? wb_i.CTI   : '0;
    assign m2_o.BTE   = w_port_en[2] ? wb_i.BTE   : '0;

    assign m3_o.CYC   = w_port_en[3] & wb_i.CYC;
    assign m3_o.STB   = w_port_en[3] & wb_i.STB;
    assign m3_o.ADR   = w_port_en[3] ? wb_i.ADR   : '0;
    assign m3_o.DAT_W = w_port_en[3] ? wb_i.DAT_W : '0;
    assign m3_o.WE    = w_port_en[3] & wb_i.WE;
    assign m3_o.SEL   = w_port_en[3] ? wb_i.SEL   : '0;
    assign m3_o.CTI   = w_port_en[3] ? wb_i.CTI   : '0;
    assign m3_o.BTE   = w_port_en[3] ? wb_i.BTE   : '0;

endmodule
